// File: rtl/mem_reg_bank.sv
// mem_reg_bank: DEPTH x WIDTH register bank with a valid bit per entry.
//
// Ports:
//   clk      - system clock, rising edge
//   reset    - asynchronous active-high reset, clears the whole bank
//   enter    - load D into entry wr_addr
//   set      - load PRESET into entry wr_addr (wins over enter)
//   clr      - invalidate entry wr_addr (lowest priority, data retained)
//   wr_addr  - target entry for enter/set/clr
//   D        - write data
//   rd_en    - read request
//   rd_addr  - entry to read
//   Q        - registered read data
//   Q_valid  - valid bit of the entry read
//   rd_ack   - one-cycle pulse, Q/Q_valid updated this cycle
//   count    - number of valid entries (registered)
//   full     - count == DEPTH (registered)
module mem_reg_bank #(
  parameter int unsigned      WIDTH  = 8,
  parameter int unsigned      DEPTH  = 4,
  parameter logic [WIDTH-1:0] PRESET = {WIDTH{1'b1}},
  localparam int unsigned     AW     = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enter,
  input  logic             set,
  input  logic             clr,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] D,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] Q,
  output logic             Q_valid,
  output logic             rd_ack,
  output logic [AW:0]      count,
  output logic             full
);

  localparam logic [AW:0] DepthW = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [AW:0]      count_q, count_d;
  logic             full_q, full_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             q_valid_q, q_valid_d;
  logic             rd_ack_q, rd_ack_d;

  logic wr_ok, rd_ok;

  // Addresses beyond DEPTH only exist when DEPTH is not a power of two.
  assign wr_ok = ({1'b0, wr_addr} < DepthW);
  assign rd_ok = ({1'b0, rd_addr} < DepthW);

  // Write side: set > enter > clr.
  always_comb begin
    mem_d   = mem_q;
    valid_d = valid_q;
    if (wr_ok) begin
      if (set) begin
        mem_d[wr_addr]   = PRESET;
        valid_d[wr_addr] = 1'b1;
      end else if (enter) begin
        mem_d[wr_addr]   = D;
        valid_d[wr_addr] = 1'b1;
      end else if (clr) begin
        valid_d[wr_addr] = 1'b0;
      end
    end
  end

  // Occupancy is the population count of the post-edge valid bits, which
  // gives the +1/-1/no-change behaviour on every valid transition.
  always_comb begin
    count_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count_d = count_d + {{AW{1'b0}}, valid_d[i]};
    end
    full_d = (count_d == DepthW);
  end

  // Read side samples pre-edge state, so same-address writes are not seen.
  always_comb begin
    q_d       = q_q;
    q_valid_d = q_valid_q;
    rd_ack_d  = 1'b0;
    if (rd_en) begin
      rd_ack_d = 1'b1;
      if (rd_ok) begin
        q_d       = mem_q[rd_addr];
        q_valid_d = valid_q[rd_addr];
      end else begin
        q_d       = '0;
        q_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      valid_q   <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      q_q       <= '0;
      q_valid_q <= 1'b0;
      rd_ack_q  <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      valid_q   <= valid_d;
      count_q   <= count_d;
      full_q    <= full_d;
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
      rd_ack_q  <= rd_ack_d;
    end
  end

  assign Q       = q_q;
  assign Q_valid = q_valid_q;
  assign rd_ack  = rd_ack_q;
  assign count   = count_q;
  assign full    = full_q;

endmodule

// File: tb/tb_mem_reg_bank.sv
// Self-checking bench for mem_reg_bank: a DEPTH=4 instance exercised with the
// directed scenarios plus random traffic, and a DEPTH=3 instance sharing the
// same inputs to cover out-of-range addresses.
module tb_mem_reg_bank;

  logic       clk;
  logic       reset;
  logic       enter;
  logic       set_en;
  logic       clr;
  logic [1:0] wr_addr;
  logic [7:0] d;
  logic       rd_en;
  logic [1:0] rd_addr;

  logic [7:0] q4, q3;
  logic       qv4, qv3;
  logic       ack4, ack3;
  logic [2:0] count4, count3;
  logic       full4, full3;

  int errors = 0;
  int checks = 0;

  // Behavioural model: plain arrays of entries and valid flags.
  logic [7:0] m4d [4];
  bit         m4v [4];
  logic [7:0] m3d [3];
  bit         m3v [3];
  logic [7:0] e4q, e3q;
  bit         e4qv, e3qv, e4ack, e3ack;

  mem_reg_bank #(.WIDTH(8), .DEPTH(4)) u_dut4 (
    .clk     (clk),
    .reset   (reset),
    .enter   (enter),
    .set     (set_en),
    .clr     (clr),
    .wr_addr (wr_addr),
    .D       (d),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .Q       (q4),
    .Q_valid (qv4),
    .rd_ack  (ack4),
    .count   (count4),
    .full    (full4)
  );

  mem_reg_bank #(.WIDTH(8), .DEPTH(3)) u_dut3 (
    .clk     (clk),
    .reset   (reset),
    .enter   (enter),
    .set     (set_en),
    .clr     (clr),
    .wr_addr (wr_addr),
    .D       (d),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .Q       (q3),
    .Q_valid (qv3),
    .rd_ack  (ack3),
    .count   (count3),
    .full    (full3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int cnt4();
    int n = 0;
    for (int i = 0; i < 4; i++) n += int'(m4v[i]);
    return n;
  endfunction

  function automatic int cnt3();
    int n = 0;
    for (int i = 0; i < 3; i++) n += int'(m3v[i]);
    return n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin m4d[i] = '0; m4v[i] = 0; end
    for (int i = 0; i < 3; i++) begin m3d[i] = '0; m3v[i] = 0; end
    e4q = '0; e4qv = 0; e4ack = 0;
    e3q = '0; e3qv = 0; e3ack = 0;
  endtask

  task automatic idle_inputs();
    enter = 0; set_en = 0; clr = 0; wr_addr = '0; d = '0; rd_en = 0; rd_addr = '0;
  endtask

  // Advance the model by one edge (read-first, then write), then clock the DUTs.
  task automatic tick();
    if (rd_en) begin
      e4ack = 1; e4q = m4d[rd_addr]; e4qv = m4v[rd_addr];
      e3ack = 1;
      if (rd_addr < 3) begin e3q = m3d[rd_addr]; e3qv = m3v[rd_addr]; end
      else begin e3q = '0; e3qv = 0; end
    end else begin
      e4ack = 0; e3ack = 0;
    end
    if (set_en) begin m4d[wr_addr] = 8'hFF; m4v[wr_addr] = 1; end
    else if (enter) begin m4d[wr_addr] = d; m4v[wr_addr] = 1; end
    else if (clr) m4v[wr_addr] = 0;
    if (wr_addr < 3) begin
      if (set_en) begin m3d[wr_addr] = 8'hFF; m3v[wr_addr] = 1; end
      else if (enter) begin m3d[wr_addr] = d; m3v[wr_addr] = 1; end
      else if (clr) m3v[wr_addr] = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if (q4 !== 8'h00 || qv4 !== 1'b0 || ack4 !== 1'b0 || count4 !== 3'd0 || full4 !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got Q=%h Qv=%b ack=%b count=%0d full=%b want all 0",
               q4, qv4, ack4, count4, full4);
    end
    reset = 0;
    for (int i = 0; i < 4; i++) begin
      rd_en = 1; rd_addr = 2'(i);
      tick();
      checks++;
      if (q4 !== 8'h00 || qv4 !== 1'b0) begin
        errors++;
        $display("FAIL reset_read%0d got Q=%h Qv=%b want Q=00 Qv=0", i, q4, qv4);
      end
      checks++;
      if (ack4 !== 1'b1 || count4 !== 3'd0) begin
        errors++;
        $display("FAIL reset_ack%0d got ack=%b count=%0d want ack=1 count=0", i, ack4, count4);
      end
    end
    rd_en = 0;
    tick();
    checks++;
    if (ack4 !== 1'b0) begin
      errors++;
      $display("FAIL reset_ack_drop got ack=%b want 0", ack4);
    end
  endtask

  task automatic test_enter_read();
    enter = 1; wr_addr = 2'd1; d = 8'hA5; tick();
    wr_addr = 2'd2; d = 8'h3C; tick();
    enter = 0;
    rd_en = 1; rd_addr = 2'd1; tick();
    checks++;
    if (q4 !== 8'hA5 || qv4 !== 1'b1 || ack4 !== 1'b1) begin
      errors++;
      $display("FAIL enter_read1 got Q=%h Qv=%b ack=%b want Q=a5 Qv=1 ack=1", q4, qv4, ack4);
    end
    rd_addr = 2'd2; tick();
    checks++;
    if (q4 !== 8'h3C || qv4 !== 1'b1 || count4 !== 3'd2) begin
      errors++;
      $display("FAIL enter_read2 got Q=%h Qv=%b count=%0d want Q=3c Qv=1 count=2",
               q4, qv4, count4);
    end
    rd_en = 0;
  endtask

  task automatic test_priority_full();
    set_en = 1; enter = 1; wr_addr = 2'd0; d = 8'h11; tick();
    set_en = 0; enter = 0;
    checks++;
    if (count4 !== 3'd3 || full4 !== 1'b0) begin
      errors++;
      $display("FAIL prio_count got count=%0d full=%b want count=3 full=0", count4, full4);
    end
    rd_en = 1; rd_addr = 2'd0; tick(); rd_en = 0;
    checks++;
    if (q4 !== 8'hFF || qv4 !== 1'b1) begin
      errors++;
      $display("FAIL prio_data got Q=%h Qv=%b want Q=ff Qv=1", q4, qv4);
    end
    enter = 1; wr_addr = 2'd3; d = 8'h5A; tick();
    checks++;
    if (count4 !== 3'd4 || full4 !== 1'b1) begin
      errors++;
      $display("FAIL fill_full got count=%0d full=%b want count=4 full=1", count4, full4);
    end
    d = 8'hC3; tick(); enter = 0;
    checks++;
    if (count4 !== 3'd4 || full4 !== 1'b1) begin
      errors++;
      $display("FAIL overwrite_count got count=%0d full=%b want count=4 full=1", count4, full4);
    end
  endtask

  task automatic test_read_during_write();
    enter = 1; wr_addr = 2'd1; d = 8'h77; rd_en = 1; rd_addr = 2'd1; tick();
    enter = 0;
    checks++;
    if (q4 !== 8'hA5 || qv4 !== 1'b1) begin
      errors++;
      $display("FAIL rdw_old got Q=%h Qv=%b want Q=a5 Qv=1", q4, qv4);
    end
    tick(); rd_en = 0;
    checks++;
    if (q4 !== 8'h77 || ack4 !== 1'b1) begin
      errors++;
      $display("FAIL rdw_new got Q=%h ack=%b want Q=77 ack=1", q4, ack4);
    end
  endtask

  task automatic test_clr();
    clr = 1; wr_addr = 2'd2; tick(); clr = 0;
    checks++;
    if (count4 !== 3'd3 || full4 !== 1'b0) begin
      errors++;
      $display("FAIL clr_count got count=%0d full=%b want count=3 full=0", count4, full4);
    end
    rd_en = 1; rd_addr = 2'd2; tick(); rd_en = 0;
    checks++;
    if (q4 !== 8'h3C || qv4 !== 1'b0) begin
      errors++;
      $display("FAIL clr_read got Q=%h Qv=%b want Q=3c Qv=0", q4, qv4);
    end
    clr = 1; wr_addr = 2'd2; tick(); clr = 0;
    checks++;
    if (count4 !== 3'd3) begin
      errors++;
      $display("FAIL clr_again got count=%0d want 3", count4);
    end
    // Idle read port holds its last value.
    rd_addr = 2'd0; tick();
    checks++;
    if (q4 !== 8'h3C || qv4 !== 1'b0 || ack4 !== 1'b0) begin
      errors++;
      $display("FAIL read_hold got Q=%h Qv=%b ack=%b want Q=3c Qv=0 ack=0", q4, qv4, ack4);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      rd_en = 1; rd_addr = 2'($urandom_range(0, 3));
      tick();
      checks++;
      if (ack4 !== 1'b1 || q4 !== e4q || qv4 !== e4qv) begin
        errors++;
        $display("FAIL b2b%0d got ack=%b Q=%h Qv=%b want ack=1 Q=%h Qv=%b",
                 i, ack4, q4, qv4, e4q, e4qv);
      end
    end
    rd_en = 0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      enter = 1'($urandom_range(0, 1));
      set_en = ($urandom_range(0, 5) == 0);
      clr = 1'($urandom_range(0, 1));
      wr_addr = 2'($urandom_range(0, 3));
      d = 8'($urandom);
      rd_en = ($urandom_range(0, 3) != 0);
      rd_addr = 2'($urandom_range(0, 3));
      tick();
      checks++;
      if (q4 !== e4q || qv4 !== e4qv || ack4 !== e4ack) begin
        errors++;
        $display("FAIL rand4_rd%0d got Q=%h Qv=%b ack=%b want Q=%h Qv=%b ack=%b",
                 i, q4, qv4, ack4, e4q, e4qv, e4ack);
      end
      checks++;
      if (count4 !== 3'(cnt4()) || full4 !== (cnt4() == 4)) begin
        errors++;
        $display("FAIL rand4_cnt%0d got count=%0d full=%b want count=%0d full=%b",
                 i, count4, full4, cnt4(), cnt4() == 4);
      end
      checks++;
      if (q3 !== e3q || qv3 !== e3qv || ack3 !== e3ack) begin
        errors++;
        $display("FAIL rand3_rd%0d got Q=%h Qv=%b ack=%b want Q=%h Qv=%b ack=%b",
                 i, q3, qv3, ack3, e3q, e3qv, e3ack);
      end
      checks++;
      if (count3 !== 3'(cnt3()) || full3 !== (cnt3() == 3)) begin
        errors++;
        $display("FAIL rand3_cnt%0d got count=%0d full=%b want count=%0d full=%b",
                 i, count3, full3, cnt3(), cnt3() == 3);
      end
    end
    idle_inputs();
  endtask

  task automatic test_async_reset();
    // Ensure entry 1 holds valid non-zero data before the reset hits.
    enter = 1; wr_addr = 2'd1; d = 8'h5C; tick(); enter = 0;
    rd_en = 1; rd_addr = 2'd1; tick();
    checks++;
    if (ack4 !== 1'b1 || q4 !== 8'h5C) begin
      errors++;
      $display("FAIL pre_reset got ack=%b Q=%h want ack=1 Q=5c", ack4, q4);
    end
    // Mid-cycle reset with the read request still asserted.
    #3 reset = 1;
    #1;
    checks++;
    if (q4 !== 8'h00 || qv4 !== 1'b0 || ack4 !== 1'b0 || count4 !== 3'd0 || full4 !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got Q=%h Qv=%b ack=%b count=%0d full=%b want all 0",
               q4, qv4, ack4, count4, full4);
    end
    model_reset();
    @(posedge clk);
    #1;
    rd_en = 0;
    reset = 0;
    tick();
    checks++;
    if (ack4 !== 1'b0 || q4 !== 8'h00 || count4 !== 3'd0) begin
      errors++;
      $display("FAIL post_reset got ack=%b Q=%h count=%0d want ack=0 Q=00 count=0",
               ack4, q4, count4);
    end
    rd_en = 1; rd_addr = 2'd1; tick(); rd_en = 0;
    checks++;
    if (q4 !== 8'h00 || qv4 !== 1'b0 || ack4 !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_read got Q=%h Qv=%b ack=%b want Q=00 Qv=0 ack=1",
               q4, qv4, ack4);
    end
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    model_reset();
    @(posedge clk);
    #1;
    test_reset();
    test_enter_read();
    test_priority_full();
    test_read_during_write();
    test_clr();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_reg_bank.md
Name: mem_reg_bank

Overview:
- Parametrised successor to the single-bit set/enable memory register: a bank of DEPTH words, each WIDTH bits, with a per-entry valid bit.
- Each entry can be written (enter), preset (set) or invalidated (clr) by address.
- A registered read port returns data plus its valid flag; live occupancy and full flags feed front-panel/display logic in lab top-levels.

Parameters:
- WIDTH, 8, bits per entry (>=1)
- DEPTH, 4, number of entries (>=2)
- PRESET, {WIDTH{1'b1}}, value loaded into an entry by set
- AW, $clog2(DEPTH), address width (derived, not overridden)

Ports:
- clk      input   1      system clock, rising edge
- reset    input   1      asynchronous, active-high; clears whole bank
- enter    input   1      write enable: load D into entry wr_addr
- set      input   1      preset enable: load PRESET into entry wr_addr
- clr      input   1      invalidate entry wr_addr
- wr_addr  input   AW     target entry for enter/set/clr
- D        input   WIDTH  write data
- rd_en    input   1      read request
- rd_addr  input   AW     entry to read
- Q        output  WIDTH  registered read data
- Q_valid  output  1      valid bit of the entry read
- rd_ack   output  1      1-cycle pulse: Q/Q_valid updated this cycle
- count    output  AW+1   number of valid entries
- full     output  1      count == DEPTH

Behaviour:
- Reset (async, immediate, independent of clk):
  - all entry data = 0, all valid = 0
  - Q = 0, Q_valid = 0, rd_ack = 0, count = 0, full = 0
- Deassertion is sampled; the first rising edge after deassertion may perform operations.
- Write-side priority per cycle, for one entry wr_addr: set > enter > clr.
  - set: data <= PRESET, valid <= 1
  - enter (no set): data <= D, valid <= 1
  - clr only: valid <= 0, data retained
  - none asserted: entry holds
- wr_addr >= DEPTH (non-power-of-2 DEPTH): write-side op ignored, no state change.
- count tracks valid-bit transitions:
  - +1 when an invalid entry becomes valid
  - -1 when a valid entry is cleared
  - unchanged on overwrite of a valid entry or clr of an invalid entry
  - count never exceeds DEPTH and never underflows
  - count and full are registered; they reflect state after the edge.
- Read: rd_en sampled at edge N.
  - Q/Q_valid show entry rd_addr as it was before edge N (read-first).
  - rd_ack = 1 during cycle N+1 only.
  - Latency is 1 cycle.
- Back-to-back reads every cycle are allowed; rd_ack stays high continuously.
- Read-during-write, same address, same edge: Q returns old data and old valid. New data is visible on the next read.
- rd_en low: Q and Q_valid hold their last values; rd_ack = 0.
- rd_addr >= DEPTH: Q = 0, Q_valid = 0, rd_ack = 1.
- Reset mid-operation: any pending read is discarded, rd_ack is forced 0, and all state clears immediately.
- No combinational path from inputs to outputs.

Test Plan (WIDTH=8, DEPTH=4):
- Reset, then rd_en addr 0..3 -> Q=8'h00, Q_valid=0, rd_ack high one cycle after each request, count=0.
- enter D=8'hA5 @1; enter D=8'h3C @2; read 1, read 2 -> Q=8'hA5 then 8'h3C, Q_valid=1, count=2.
- set and enter same cycle, wr_addr=0, D=8'h11 -> entry0=8'hFF, count=3. Fill entry3 -> full=1, count=4. Overwrite entry3 -> count stays 4.
- Same edge: enter D=8'h77 @1 and rd_en addr 1 -> Q=8'hA5 (old). Next read of 1 -> Q=8'h77.
- clr @2 -> count=3, full=0; read 2 -> Q=8'h3C, Q_valid=0. clr @2 again -> count stays 3.
- Assert reset asynchronously between edges with rd_en pending -> all outputs 0 immediately, no rd_ack after release.
